// File: rtl/pm_pkg.sv
// Shared types and defaults for the DDD pacemaker controller.
// The optional upper-rate hold is enabled with the PM_URI_EN macro.
package pm_pkg;

    typedef enum logic [1:0] {
        PM_VA   = 2'd0,
        PM_AV   = 2'd1,
        PM_RSV2 = 2'd2,
        PM_RSV3 = 2'd3
    } pm_state_t;

    localparam int CNT_W_DEF  = 16;
    localparam int PACE_W_DEF = 2;

endpackage

// File: rtl/pm_interval_timer.sv
// Saturating interval timer. A clear on an enabled tick loads 1 because the
// clearing tick already counts as the first tick of the new interval.
module pm_interval_timer
    import pm_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_r;

    assign count = count_r;

    // Count register: clear/restart, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= en ? CNT_ONE : {W{1'b0}};
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pacemaker_ddd_ctrl.sv
// DDD pacemaker controller: senses A/V activation, issues AP/VP pace pulses.
// Optional macro PM_URI_EN holds the AV state until the upper-rate interval expires.
module pacemaker_ddd_ctrl
    import pm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PACE_W = PACE_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             pm_en,
    input  logic             a_sense,
    input  logic             v_sense,
    input  logic [CNT_W-1:0] LRI,
    input  logic [CNT_W-1:0] AVI,
    input  logic [CNT_W-1:0] PVARP,
    input  logic [CNT_W-1:0] VRP,
    input  logic [CNT_W-1:0] URI,
    output logic             ce_out,
    output logic             AP,
    output logic             VP,
    output logic [1:0]       pm_state
);

    localparam int PW = (PACE_W > 1) ? $clog2(PACE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PW_ONE  = PW'(1);
    localparam logic [PW-1:0]    PW_LOAD = PW'(PACE_W - 1);

    pm_state_t        state_r, next_s;
    logic             a_prev_r, v_prev_r;
    logic             pvarp_exp_r, vrp_exp_r;
    logic             ap_r, vp_r;
    logic [PW-1:0]    ap_left_r, vp_left_r;
    logic [CNT_W-1:0] va_cnt_s, av_cnt_s, pvarp_cnt_s, vrp_cnt_s, uri_cnt_s;
    logic [CNT_W-1:0] va_lim_s;
    logic             run_s, as_valid_s, vs_valid_s, uri_ok_s;
    logic             ap_req_s, vp_req_s, v_event_s, av_entry_s;
    logic             v_clr_s, av_clr_s;

    assign ce_out   = clk_enable;
    assign AP       = ap_r;
    assign VP       = vp_r;
    assign pm_state = state_r;

    assign run_s    = clk_enable & pm_en;
    assign va_lim_s = (LRI > AVI) ? (LRI - AVI) : CNT_ONE;

    // Refractory windows start "expired" after reset or disable, until the next V-event.
    assign as_valid_s = run_s & a_sense & ~a_prev_r & (pvarp_exp_r | (pvarp_cnt_s >= PVARP));
    assign vs_valid_s = run_s & v_sense & ~v_prev_r & (vrp_exp_r | (vrp_cnt_s >= VRP));

`ifdef PM_URI_EN
    assign uri_ok_s = (uri_cnt_s >= URI);
`else
    logic unused_uri_s;
    assign unused_uri_s = ^{URI, uri_cnt_s};
    assign uri_ok_s     = 1'b1;
`endif

    assign v_clr_s  = clk_enable & (v_event_s | ~pm_en);
    assign av_clr_s = clk_enable & (av_entry_s | ~pm_en);

    pm_interval_timer #(.W(CNT_W)) u_va_tmr (
        .clk(clk), .reset(reset), .clr(v_clr_s), .en(run_s), .count(va_cnt_s));
    pm_interval_timer #(.W(CNT_W)) u_av_tmr (
        .clk(clk), .reset(reset), .clr(av_clr_s), .en(run_s), .count(av_cnt_s));
    pm_interval_timer #(.W(CNT_W)) u_pvarp_tmr (
        .clk(clk), .reset(reset), .clr(v_clr_s), .en(run_s), .count(pvarp_cnt_s));
    pm_interval_timer #(.W(CNT_W)) u_vrp_tmr (
        .clk(clk), .reset(reset), .clr(v_clr_s), .en(run_s), .count(vrp_cnt_s));
    pm_interval_timer #(.W(CNT_W)) u_uri_tmr (
        .clk(clk), .reset(reset), .clr(v_clr_s), .en(run_s), .count(uri_cnt_s));

    // Next-state and pace-request decode; senses take priority over timer expiry.
    always_comb begin
        next_s     = state_r;
        ap_req_s   = 1'b0;
        vp_req_s   = 1'b0;
        v_event_s  = 1'b0;
        av_entry_s = 1'b0;
        if (run_s) begin
            case (state_r)
                PM_VA: begin
                    if (vs_valid_s) begin
                        v_event_s = 1'b1;
                    end else if (as_valid_s) begin
                        next_s     = PM_AV;
                        av_entry_s = 1'b1;
                    end else if (va_cnt_s >= va_lim_s) begin
                        next_s     = PM_AV;
                        av_entry_s = 1'b1;
                        ap_req_s   = 1'b1;
                    end else begin
                        next_s = PM_VA;
                    end
                end
                PM_AV: begin
                    if (vs_valid_s) begin
                        next_s    = PM_VA;
                        v_event_s = 1'b1;
                    end else if ((av_cnt_s >= AVI) && uri_ok_s) begin
                        next_s    = PM_VA;
                        v_event_s = 1'b1;
                        vp_req_s  = 1'b1;
                    end else begin
                        next_s = PM_AV;
                    end
                end
                default: begin
                    next_s = PM_VA;
                end
            endcase
        end else begin
            next_s = state_r;
        end
    end

    // State, sense edge history and refractory-expired flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= PM_VA;
            a_prev_r    <= 1'b0;
            v_prev_r    <= 1'b0;
            pvarp_exp_r <= 1'b1;
            vrp_exp_r   <= 1'b1;
        end else if (clk_enable) begin
            a_prev_r <= a_sense;
            v_prev_r <= v_sense;
            if (!pm_en) begin
                state_r     <= PM_VA;
                pvarp_exp_r <= 1'b1;
                vrp_exp_r   <= 1'b1;
            end else begin
                state_r <= next_s;
                if (v_event_s) begin
                    pvarp_exp_r <= 1'b0;
                    vrp_exp_r   <= 1'b0;
                end else begin
                    pvarp_exp_r <= pvarp_exp_r;
                    vrp_exp_r   <= vrp_exp_r;
                end
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Fixed-length pace pulses; a request during an active pulse is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            ap_r      <= 1'b0;
            vp_r      <= 1'b0;
            ap_left_r <= {PW{1'b0}};
            vp_left_r <= {PW{1'b0}};
        end else if (clk_enable) begin
            if (!pm_en) begin
                ap_r <= 1'b0;
                vp_r <= 1'b0;
            end else begin
                if (ap_r) begin
                    if (ap_left_r == {PW{1'b0}}) ap_r <= 1'b0;
                    else ap_left_r <= ap_left_r - PW_ONE;
                end else if (ap_req_s) begin
                    ap_r      <= 1'b1;
                    ap_left_r <= PW_LOAD;
                end else begin
                    ap_r <= 1'b0;
                end
                if (vp_r) begin
                    if (vp_left_r == {PW{1'b0}}) vp_r <= 1'b0;
                    else vp_left_r <= vp_left_r - PW_ONE;
                end else if (vp_req_s) begin
                    vp_r      <= 1'b1;
                    vp_left_r <= PW_LOAD;
                end else begin
                    vp_r <= 1'b0;
                end
            end
        end else begin
            ap_r <= ap_r;
            vp_r <= vp_r;
        end
    end

endmodule

// File: tb/tb_pacemaker_ddd_ctrl.sv
// Scoreboard bench for pacemaker_ddd_ctrl: expected pace pulses (tick, width)
// are queued per scenario and matched against observed AP/VP rising edges.
module tb_pacemaker_ddd_ctrl;

    localparam int PACE_W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        pm_en = 1'b1;
    logic        a_sense = 1'b0;
    logic        v_sense = 1'b0;
    logic [15:0] LRI = 16'd1000;
    logic [15:0] AVI = 16'd200;
    logic [15:0] PVARP = 16'd250;
    logic [15:0] VRP = 16'd150;
    logic [15:0] URI = 16'd500;
    logic        ce_out, AP, VP;
    logic [1:0]  pm_state;

    int tick_n = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic is_vp;
        int   tick;
        int   width;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic ap_d = 1'b0, vp_d = 1'b0;
    int   ap_w = 0, vp_w = 0, ap_exp_w = 0, vp_exp_w = 0;

    pacemaker_ddd_ctrl #(.CNT_W(16), .PACE_W(PACE_W)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .pm_en(pm_en),
        .a_sense(a_sense), .v_sense(v_sense),
        .LRI(LRI), .AVI(AVI), .PVARP(PVARP), .VRP(VRP), .URI(URI),
        .ce_out(ce_out), .AP(AP), .VP(VP), .pm_state(pm_state));

    always #5 clk = ~clk;

    // Tick n = n-th enabled rising edge after reset release.
    always @(posedge clk) begin
        if (reset) tick_n <= 0;
        else if (clk_enable) tick_n <= tick_n + 1;
    end

    // Pulse monitor: pops the scoreboard on each rise, checks width on each fall.
    always @(negedge clk) begin
        if (AP && !ap_d) begin
            ap_w = 1;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL ap_unexpected: AP rose at tick %0d, none expected", tick_n);
                ap_exp_w = PACE_W;
            end else begin
                e = sb.pop_front();
                if (e.is_vp !== 1'b0 || e.tick != tick_n) begin
                    n_fail++;
                    $display("FAIL ap_rise: got AP@%0d, expected %s@%0d", tick_n, e.is_vp ? "VP" : "AP", e.tick);
                end
                ap_exp_w = e.width;
            end
        end else if (AP) begin
            ap_w++;
        end else if (ap_d) begin
            n_checks++;
            if (ap_w != ap_exp_w) begin
                n_fail++;
                $display("FAIL ap_width: got %0d ticks, expected %0d (fell at tick %0d)", ap_w, ap_exp_w, tick_n);
            end
        end
        if (VP && !vp_d) begin
            vp_w = 1;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL vp_unexpected: VP rose at tick %0d, none expected", tick_n);
                vp_exp_w = PACE_W;
            end else begin
                e = sb.pop_front();
                if (e.is_vp !== 1'b1 || e.tick != tick_n) begin
                    n_fail++;
                    $display("FAIL vp_rise: got VP@%0d, expected %s@%0d", tick_n, e.is_vp ? "VP" : "AP", e.tick);
                end
                vp_exp_w = e.width;
            end
        end else if (VP) begin
            vp_w++;
        end else if (vp_d) begin
            n_checks++;
            if (vp_w != vp_exp_w) begin
                n_fail++;
                $display("FAIL vp_width: got %0d ticks, expected %0d (fell at tick %0d)", vp_w, vp_exp_w, tick_n);
            end
        end
        ap_d = AP;
        vp_d = VP;
    end

    task automatic push(input logic is_vp, input int tick, input int width);
        exp_t x;
        x.is_vp = is_vp;
        x.tick  = tick;
        x.width = width;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clk_enable = 1'b1;
        pm_en = 1'b1;
        a_sense = 1'b0;
        v_sense = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to(input int t);
        int guard;
        guard = 0;
        while (tick_n < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (tick_n < t) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to_timeout: at tick %0d, wanted tick %0d", tick_n, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 4;
        if (AP !== 1'b0) begin n_fail++; $display("FAIL reset_ap: got %b, expected 0", AP); end
        if (VP !== 1'b0) begin n_fail++; $display("FAIL reset_vp: got %b, expected 0", VP); end
        if (pm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", pm_state); end
        if (ce_out !== 1'b1) begin n_fail++; $display("FAIL ce_out_hi: got %b, expected 1", ce_out); end
        clk_enable = 1'b0;
        #1;
        n_checks++;
        if (ce_out !== 1'b0) begin n_fail++; $display("FAIL ce_out_lo: got %b, expected 0", ce_out); end
        clk_enable = 1'b1;
    endtask

    task automatic test_no_sense();
        do_reset();
        push(1'b0, 801, 2); push(1'b1, 1001, 2); push(1'b0, 1801, 2); push(1'b1, 2001, 2);
        run_to(500);
        clk_enable = 1'b0;
        repeat (30) @(negedge clk);
        clk_enable = 1'b1;
        run_to(900);
        n_checks++;
        if (pm_state !== 2'd1) begin n_fail++; $display("FAIL nosense_state_av: got %0d, expected 1", pm_state); end
        run_to(2010);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL nosense_drain: %0d pulses missing", sb.size()); sb.delete(); end
    endtask

    task automatic test_atrial_sense();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            push(1'b1, 501, 2);
            if (k == 0) begin push(1'b0, 1301, 2); push(1'b1, 1501, 2); end
            else push(1'b1, 951, 2);
            run_to(300);
            a_sense = 1'b1;
            run_to(301);
            n_checks++;
            if (pm_state !== 2'd1) begin n_fail++; $display("FAIL as_enter_av: got %0d, expected 1", pm_state); end
            run_to(302);
            a_sense = 1'b0;
            run_to(749 + k);
            a_sense = 1'b1;
            run_to(750 + k);
            n_checks++;
            if (pm_state !== ((k == 1) ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL pvarp_edge_%0d: got state %0d, expected %0d", k, pm_state, k);
            end
            run_to(760);
            a_sense = 1'b0;
            run_to((k == 1) ? 960 : 1510);
            n_checks++;
            if (sb.size() != 0) begin n_fail++; $display("FAIL as_drain_%0d: %0d pulses missing", k, sb.size()); sb.delete(); end
        end
    endtask

    task automatic test_vrp();
        do_reset();
        push(1'b0, 801, 2); push(1'b1, 1001, 2); push(1'b0, 2201, 2); push(1'b1, 2401, 2);
        run_to(1100);
        v_sense = 1'b1;
        run_to(1101);
        v_sense = 1'b0;
        run_to(1400);
        v_sense = 1'b1;
        run_to(1402);
        v_sense = 1'b0;
        run_to(2410);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL vrp_drain: %0d pulses missing", sb.size()); sb.delete(); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        push(1'b0, 801, 2); push(1'b1, 1001, 2); push(1'b0, 2101, 2); push(1'b1, 2301, 2);
        run_to(1300);
        a_sense = 1'b1;
        v_sense = 1'b1;
        run_to(1301);
        n_checks++;
        if (pm_state !== 2'd0) begin n_fail++; $display("FAIL simul_state: got %0d, expected 0", pm_state); end
        run_to(1302);
        a_sense = 1'b0;
        v_sense = 1'b0;
        run_to(1400);
        n_checks++;
        if (pm_state !== 2'd0) begin n_fail++; $display("FAIL simul_state_later: got %0d, expected 0", pm_state); end
        run_to(2310);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL simul_drain: %0d pulses missing", sb.size()); sb.delete(); end
    endtask

    task automatic test_pm_en();
        do_reset();
        push(1'b0, 801, 1); push(1'b0, 1701, 2); push(1'b1, 1901, 2);
        run_to(801);
        pm_en = 1'b0;
        run_to(802);
        n_checks += 2;
        if (AP !== 1'b0) begin n_fail++; $display("FAIL pmen_ap_cut: got %b, expected 0", AP); end
        if (pm_state !== 2'd0) begin n_fail++; $display("FAIL pmen_state: got %0d, expected 0", pm_state); end
        run_to(900);
        pm_en = 1'b1;
        run_to(1910);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL pmen_drain: %0d pulses missing", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        push(1'b0, 801, 1);
        run_to(801);
        reset = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (AP !== 1'b0) begin n_fail++; $display("FAIL rstpulse_ap: got %b, expected 0", AP); end
        if (VP !== 1'b0) begin n_fail++; $display("FAIL rstpulse_vp: got %b, expected 0", VP); end
        if (pm_state !== 2'd0) begin n_fail++; $display("FAIL rstpulse_state: got %0d, expected 0", pm_state); end
        reset = 1'b0;
        push(1'b0, 801, 2);
        run_to(810);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rstpulse_drain: %0d pulses missing", sb.size()); sb.delete(); end
    endtask

    task automatic test_uri();
        logic [1:0] exp_state;
        URI = 16'd1100;
        do_reset();
        push(1'b0, 801, 2);
`ifdef PM_URI_EN
        push(1'b1, 1101, 2);
        exp_state = 2'd1;
`else
        push(1'b1, 1001, 2);
        exp_state = 2'd0;
`endif
        run_to(1050);
        n_checks++;
        if (pm_state !== exp_state) begin n_fail++; $display("FAIL uri_state: got %0d, expected %0d", pm_state, exp_state); end
        run_to(1110);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL uri_drain: %0d pulses missing", sb.size()); sb.delete(); end
        URI = 16'd500;
    endtask

    initial begin
        test_reset();
        test_no_sense();
        test_atrial_sense();
        test_vrp();
        test_simultaneous();
        test_pm_en();
        test_reset_mid_pulse();
        test_uri();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at tick %0d", tick_n);
        $fatal(1, "watchdog expired");
    end

endmodule
